cruce_ctrl: RTL and testbench
=============================

Name: cruce_ctrl

Overview:
- Two-way intersection controller that sequences the north-south (NS) and east-west (EW) traffic-light lamp sets.
- Inserts an all-red clearance between the two directions.
- Serves a latched pedestrian request with a dedicated walk phase.
- Sits above the per-direction lamp drivers. It is the single block that decides which direction owns the crossing.

Parameters:
GREEN_T, 8, green duration in clock cycles (>=1)
YELLOW_T, 2, yellow duration in cycles (>=1)
ALLRED_T, 1, all-red clearance duration in cycles (>=1)
PED_T, 4, pedestrian walk duration in cycles (>=1)
CNT_W, 4, phase timer width; must hold max(all durations)-1

Ports:
clk  in  1  single clock, rising edge
rst  in  1  reset, synchronous, active-high
ped_req  in  1  pedestrian button; rising edge is a request
ped_ack  out  1  one-cycle pulse: request accepted
ns_green  out  1  NS green lamp
ns_yellow  out  1  NS yellow lamp
ns_red  out  1  NS red lamp
ew_green  out  1  EW green lamp
ew_yellow  out  1  EW yellow lamp
ew_red  out  1  EW red lamp
walk  out  1  pedestrian walk lamp
phase  out  3  current state code, for debug and verification

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- States: NS_GRN, NS_YEL, ALLRED, EW_GRN, EW_YEL, PED_WALK.
- State flops:
  - state;
  - down-counter tmr[CNT_W-1:0];
  - next_dir (0 = NS next, 1 = EW next);
  - ped_pending;
  - ped_q, the previous ped_req, used for edge detection.
- Reset (rst sampled high):
  - state=NS_GRN, tmr=GREEN_T-1, next_dir=1, ped_pending=0, ped_q=0, ped_ack=0.
  - Outputs in the cycle after the reset edge: ns_green=1, ew_red=1, all other lamps 0, walk=0.
  - Reset applied mid-operation behaves identically and discards any pending request.
- Timing:
  - Each state is held for exactly its duration in cycles.
  - On entry, tmr is loaded with T-1. The transition occurs on the edge where tmr==0; otherwise tmr decrements.
- Transitions:
  - NS_GRN->NS_YEL.
  - NS_YEL->ALLRED with next_dir=1.
  - EW_GRN->EW_YEL.
  - EW_YEL->ALLRED with next_dir=0.
  - ALLRED end: if ped_pending, go to PED_WALK and clear ped_pending. Otherwise go to EW_GRN if next_dir=1, else NS_GRN.
  - PED_WALK end: go to the green of the direction selected by next_dir.
- Outputs are Moore, decoded from the registered state:
  - Exactly one lamp per direction is high every cycle.
  - In ALLRED and PED_WALK, both directions are red.
  - walk=1 only in PED_WALK.
- Pedestrian handshake:
  - Request event: ped_req & ~ped_q.
  - If an event occurs while ped_pending==0, set ped_pending and pulse ped_ack in the next cycle.
  - Events while already pending are ignored, with no ack. A held button therefore produces one ack.
  - An event in the same cycle that ped_pending is being cleared (ALLRED->PED_WALK edge) is accepted: pending stays 1 and ack pulses. It is served at the next ALLRED.
- Baseline cycle length with no pedestrian request: 2*(GREEN_T+YELLOW_T+ALLRED_T), which is 22 cycles with defaults.

Decomposition:
- Package cruce_pkg holds:
  - the state encodings, with fixed 3-bit codes NS_GRN=0, NS_YEL=1, ALLRED=2, EW_GRN=3, EW_YEL=4, PED_WALK=5;
  - the direction constants DIR_NS/DIR_EW.
- One natural sub-module, phase_timer: a loadable CNT_W-bit down-counter with inputs load and load_val, and output done (tmr==0). It takes clk and rst.

Test Plan:
- Defaults, reset then 44 cycles, no ped_req (cycles counted from the first cycle after reset is released):
  - NS green cycles 0-7, yellow 8-9, allred 10;
  - EW green 11-18, yellow 19-20, allred 21;
  - NS green again at 22, with the pattern repeating at 44.
- ped_req pulse at cycle 3:
  - ped_ack high cycle 4 only;
  - allred 10, walk=1 cycles 11-14 with both directions red;
  - EW green 15-22.
- ped_req held high cycles 3-30 -> exactly one ped_ack, exactly one walk phase (11-14), no second walk.
- Second ped_req edge during PED_WALK (cycle 12):
  - ped_ack at 13;
  - walk again after the allred following EW yellow.
- rst asserted one cycle during EW_GRN with a request pending -> next cycle ns_green=1, ew_red=1, phase=0; no walk at the following ALLRED.
- Continuous invariant checks, all cycles and all scenarios:
  - one-hot lamps per direction;
  - never a non-red lamp on both directions at once;
  - walk implies ns_red & ew_red.

Source files
------------

// File: rtl/cruce_pkg.sv
// Shared types for the intersection controller: phase codes, direction constants
// and the lamp decode used by the top level.
package cruce_pkg;

  typedef enum logic [2:0] {
    StNsGrn   = 3'd0,
    StNsYel   = 3'd1,
    StAllRed  = 3'd2,
    StEwGrn   = 3'd3,
    StEwYel   = 3'd4,
    StPedWalk = 3'd5
  } state_e;

  localparam logic DIR_NS = 1'b0;
  localparam logic DIR_EW = 1'b1;

  typedef struct packed {
    logic ns_green;
    logic ns_yellow;
    logic ns_red;
    logic ew_green;
    logic ew_yellow;
    logic ew_red;
    logic walk;
  } lamps_t;

  function automatic lamps_t lamps_of(input state_e s);
    lamps_t l;
    l = '0;
    case (s)
      StNsGrn:   begin l.ns_green  = 1'b1; l.ew_red    = 1'b1; end
      StNsYel:   begin l.ns_yellow = 1'b1; l.ew_red    = 1'b1; end
      StEwGrn:   begin l.ns_red    = 1'b1; l.ew_green  = 1'b1; end
      StEwYel:   begin l.ns_red    = 1'b1; l.ew_yellow = 1'b1; end
      StPedWalk: begin l.ns_red    = 1'b1; l.ew_red    = 1'b1; l.walk = 1'b1; end
      // All-red also covers the unused codes so a corrupted state never shows a go lamp.
      default:   begin l.ns_red    = 1'b1; l.ew_red    = 1'b1; end
    endcase
    return l;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter that times each phase; done flags the last cycle of a phase.
module phase_timer #(
  parameter int unsigned     CNT_W   = 4,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] tmr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      tmr_q <= RST_VAL;
    end else if (load) begin
      tmr_q <= load_val;
    end else if (tmr_q != '0) begin
      tmr_q <= tmr_q - 1'b1;
    end
  end

  assign done = (tmr_q == '0);

endmodule

// File: rtl/cruce_ctrl.sv
// Two-way intersection controller with all-red clearance and a latched pedestrian walk phase.
module cruce_ctrl
  import cruce_pkg::*;
#(
  parameter int unsigned GREEN_T  = 8,
  parameter int unsigned YELLOW_T = 2,
  parameter int unsigned ALLRED_T = 1,
  parameter int unsigned PED_T    = 4,
  parameter int unsigned CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ped_req,
  output logic       ped_ack,
  output logic       ns_green,
  output logic       ns_yellow,
  output logic       ns_red,
  output logic       ew_green,
  output logic       ew_yellow,
  output logic       ew_red,
  output logic       walk,
  output logic [2:0] phase
);

  state_e           state_q, state_d;
  logic             next_dir_q, next_dir_d;
  logic             ped_pending_q, ped_pending_d;
  logic             ped_q;
  logic             ped_ack_d;
  logic             ped_clear;
  logic             ped_event;
  logic             done;
  logic [CNT_W-1:0] load_val;
  lamps_t           lamps_q;

  function automatic logic [CNT_W-1:0] dur_m1(input state_e s);
    case (s)
      StNsGrn, StEwGrn: return CNT_W'(GREEN_T - 1);
      StNsYel, StEwYel: return CNT_W'(YELLOW_T - 1);
      StPedWalk:        return CNT_W'(PED_T - 1);
      default:          return CNT_W'(ALLRED_T - 1);
    endcase
  endfunction

  always_comb begin
    state_d    = state_q;
    next_dir_d = next_dir_q;
    ped_clear  = 1'b0;
    if (done) begin
      case (state_q)
        StNsGrn: state_d = StNsYel;
        StNsYel: begin
          state_d    = StAllRed;
          next_dir_d = DIR_EW;
        end
        StEwGrn: state_d = StEwYel;
        StEwYel: begin
          state_d    = StAllRed;
          next_dir_d = DIR_NS;
        end
        StAllRed: begin
          if (ped_pending_q) begin
            state_d   = StPedWalk;
            ped_clear = 1'b1;
          end else begin
            state_d = (next_dir_q == DIR_EW) ? StEwGrn : StNsGrn;
          end
        end
        StPedWalk: state_d = (next_dir_q == DIR_EW) ? StEwGrn : StNsGrn;
        default:   state_d = StNsGrn;
      endcase
    end
  end

  // A new press on the very edge that consumes the pending request is kept for the next clearance.
  assign ped_event     = ped_req & ~ped_q;
  assign ped_ack_d     = ped_event & (~ped_pending_q | ped_clear);
  assign ped_pending_d = ped_ack_d | (ped_pending_q & ~ped_clear);
  assign load_val      = dur_m1(state_d);

  phase_timer #(
    .CNT_W   (CNT_W),
    .RST_VAL (CNT_W'(GREEN_T - 1))
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (done),
    .load_val (load_val),
    .done     (done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StNsGrn;
      next_dir_q    <= DIR_EW;
      ped_pending_q <= 1'b0;
      ped_q         <= 1'b0;
      ped_ack       <= 1'b0;
      lamps_q       <= lamps_of(StNsGrn);
    end else begin
      state_q       <= state_d;
      next_dir_q    <= next_dir_d;
      ped_pending_q <= ped_pending_d;
      ped_q         <= ped_req;
      ped_ack       <= ped_ack_d;
      lamps_q       <= lamps_of(state_d);
    end
  end

  assign ns_green  = lamps_q.ns_green;
  assign ns_yellow = lamps_q.ns_yellow;
  assign ns_red    = lamps_q.ns_red;
  assign ew_green  = lamps_q.ew_green;
  assign ew_yellow = lamps_q.ew_yellow;
  assign ew_red    = lamps_q.ew_red;
  assign walk      = lamps_q.walk;
  assign phase     = state_q;

endmodule

// File: tb/tb_cruce_ctrl.sv
// Self-checking bench: phase-schedule reference model, per-cycle compare, directed scenarios
// with literal expectations and a randomized button/reset soak.
module tb_cruce_ctrl;

  localparam int GT = 8;
  localparam int YT = 2;
  localparam int AT = 1;
  localparam int PT = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ped_req = 1'b0;
  logic       ped_ack;
  logic       ns_green, ns_yellow, ns_red, ew_green, ew_yellow, ew_red, walk;
  logic [2:0] phase;

  int checks = 0;
  int errors = 0;

  cruce_ctrl #(
    .GREEN_T  (GT),
    .YELLOW_T (YT),
    .ALLRED_T (AT),
    .PED_T    (PT),
    .CNT_W    (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ped_req   (ped_req),
    .ped_ack   (ped_ack),
    .ns_green  (ns_green),
    .ns_yellow (ns_yellow),
    .ns_red    (ns_red),
    .ew_green  (ew_green),
    .ew_yellow (ew_yellow),
    .ew_red    (ew_red),
    .walk      (walk),
    .phase     (phase)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase code, cycles spent in it, and the pedestrian bookkeeping.
  int   m_phase, m_el;
  logic m_dir, m_pend, m_pq, m_ack;
  bit   valid = 0;

  function automatic int dur(input int p);
    case (p)
      0, 3:    return GT;
      1, 4:    return YT;
      5:       return PT;
      default: return AT;
    endcase
  endfunction

  // {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk}
  function automatic logic [6:0] exp_lamps(input int p);
    case (p)
      0:       return 7'b100_001_0;
      1:       return 7'b010_001_0;
      3:       return 7'b001_100_0;
      4:       return 7'b001_010_0;
      5:       return 7'b001_001_1;
      default: return 7'b001_001_0;
    endcase
  endfunction

  task automatic model_step();
    logic ev, clr;
    int   nxt;
    if (rst) begin
      m_phase = 0; m_el = 0; m_dir = 1'b1; m_pend = 1'b0; m_pq = 1'b0; m_ack = 1'b0;
      valid   = 1;
    end else begin
      ev  = ped_req && !m_pq;
      clr = 1'b0;
      nxt = m_phase;
      if (m_el + 1 >= dur(m_phase)) begin
        m_el = 0;
        case (m_phase)
          0: nxt = 1;
          1: begin nxt = 2; m_dir = 1'b1; end
          3: nxt = 4;
          4: begin nxt = 2; m_dir = 1'b0; end
          2: begin
            if (m_pend) begin nxt = 5; clr = 1'b1; end
            else nxt = m_dir ? 3 : 0;
          end
          default: nxt = m_dir ? 3 : 0;
        endcase
      end else begin
        m_el++;
      end
      m_phase = nxt;
      m_ack   = ev && (!m_pend || clr);
      if (m_ack) m_pend = 1'b1;
      else if (clr) m_pend = 1'b0;
      m_pq = ped_req;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Per-cycle compare against the model plus the lamp safety invariants.
  initial forever begin
    @(negedge clk);
    if (valid) begin
      chk("lamps", {ns_green, ns_yellow, ns_red, ew_green, ew_yellow, ew_red, walk},
          exp_lamps(m_phase));
      chk("phase", phase, m_phase[2:0]);
      chk("ped_ack", ped_ack, m_ack);
      chk("ns_onehot", $onehot({ns_green, ns_yellow, ns_red}), 1);
      chk("ew_onehot", $onehot({ew_green, ew_yellow, ew_red}), 1);
      chk("no_conflict", !ns_red && !ew_red, 0);
      chk("walk_red", walk && !(ns_red && ew_red), 0);
    end
  end

  // Leaves the bench at the negedge of cycle 0.
  task automatic do_reset();
    @(negedge clk);
    rst     = 1'b1;
    ped_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  int acks, walks;

  initial begin
    // Baseline schedule, no pedestrian.
    do_reset();
    for (int c = 0; c <= 44; c++) begin
      if (c == 0)  chk("s1_c0_nsg", {ns_green, ew_red, walk, phase}, {3'b110, 3'd0});
      if (c == 7)  chk("s1_c7", phase, 0);
      if (c == 8)  chk("s1_c8", phase, 1);
      if (c == 10) chk("s1_c10", phase, 2);
      if (c == 11) chk("s1_c11", phase, 3);
      if (c == 18) chk("s1_c18", phase, 3);
      if (c == 19) chk("s1_c19", phase, 4);
      if (c == 21) chk("s1_c21", phase, 2);
      if (c == 22) chk("s1_c22", phase, 0);
      if (c == 44) chk("s1_c44", phase, 0);
      if (c == 10) chk("s1_model_c10", m_phase, 2);
      @(negedge clk);
    end

    // Single pulse at cycle 3.
    do_reset();
    for (int c = 0; c < 26; c++) begin
      if (c == 3)  chk("s2_ack3", ped_ack, 0);
      if (c == 4)  chk("s2_ack4", ped_ack, 1);
      if (c == 5)  chk("s2_ack5", ped_ack, 0);
      if (c == 10) chk("s2_allred", phase, 2);
      if (c == 11) chk("s2_walk11", {walk, ns_red, ew_red}, 3'b111);
      if (c == 14) chk("s2_walk14", {walk, phase}, {1'b1, 3'd5});
      if (c == 15) chk("s2_ewg15", {walk, ew_green}, 2'b01);
      if (c == 22) chk("s2_ewg22", phase, 3);
      if (c == 23) chk("s2_ewy23", phase, 4);
      ped_req = (c == 3);
      @(negedge clk);
    end

    // Held button: one ack, one walk phase.
    do_reset();
    acks  = 0;
    walks = 0;
    for (int c = 0; c < 61; c++) begin
      if (ped_ack) acks++;
      if (walk) walks++;
      if (c == 11) chk("s3_walk11", walk, 1);
      ped_req = (c >= 3 && c <= 30);
      @(negedge clk);
    end
    chk("s3_acks", acks, 1);
    chk("s3_walks", walks, 4);

    // Second edge during the walk phase is served after the next clearance.
    do_reset();
    for (int c = 0; c < 32; c++) begin
      if (c == 13) chk("s4_ack13", ped_ack, 1);
      if (c == 25) chk("s4_allred25", phase, 2);
      if (c == 26) chk("s4_walk26", walk, 1);
      if (c == 29) chk("s4_walk29", walk, 1);
      if (c == 30) chk("s4_nsg30", {walk, ns_green}, 2'b01);
      ped_req = (c == 3) || (c == 12);
      @(negedge clk);
    end

    // Edge on the same cycle the pending request is consumed is still accepted.
    do_reset();
    for (int c = 0; c < 28; c++) begin
      if (c == 11) chk("s4b_ack11", {ped_ack, walk}, 2'b11);
      if (c == 26) chk("s4b_walk26", walk, 1);
      ped_req = (c == 3) || (c == 10);
      @(negedge clk);
    end

    // Reset during EW green with a pending request discards it.
    do_reset();
    for (int c = 0; c < 30; c++) begin
      if (c == 13) chk("s5_ack13", ped_ack, 1);
      if (c == 16) chk("s5_rst", {ns_green, ew_red, walk, phase}, {3'b110, 3'd0});
      if (c == 26) chk("s5_allred", phase, 2);
      if (c == 27) chk("s5_nowalk", {walk, phase}, {1'b0, 3'd3});
      ped_req = (c == 12);
      rst     = (c == 15);
      @(negedge clk);
    end

    // Randomized button activity with occasional resets.
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 5) == 0) ped_req = ~ped_req;
      rst = ($urandom_range(0, 249) == 0);
      @(negedge clk);
    end
    rst = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
